// File: rtl/cond_branch_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_merge_pkg
// Brief    : Shared types and helpers for the generated N-way merge blocks.
// Revision : 1.0 - initial release
// ============================================================================
package cond_branch_merge_pkg;

    localparam int c_MAX_BRANCH = 256;
    localparam int c_MAX_SEL_W  = 8;

    typedef struct packed {
        logic [c_MAX_SEL_W-1:0] sel;
        logic                   else_flag;
    } sel_entry_t;

    function automatic int SEL_W(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Lowest true condition wins; no true condition selects the else branch.
    function automatic sel_entry_t prio_encode(input logic [c_MAX_BRANCH-2:0] cond,
                                               input int                      num_branch);
        sel_entry_t e;
        e.sel       = c_MAX_SEL_W'(num_branch - 1);
        e.else_flag = 1'b1;
        for (int i = c_MAX_BRANCH - 2; i >= 0; i--) begin
            if ((i < num_branch - 1) && cond[i]) begin
                e.sel       = c_MAX_SEL_W'(i);
                e.else_flag = 1'b0;
            end
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sel_fifo
// Brief    : Synchronous FIFO with count/full/empty; storage is not reset.
// Revision : 1.0 - initial release
// ============================================================================
module sel_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cond_branch_merge.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_merge
// Brief    : Priority-selects one of NUM_BRANCH variable-latency branch results,
//            queueing each selection until all branch results are present.
// Revision : 1.0 - initial release
// ============================================================================
module cond_branch_merge
    import cond_branch_merge_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_BRANCH = 4,
    parameter int DEPTH      = 4,
    parameter int ONEHOT_CHK = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_BRANCH-2:0]           cond_vec,
    input  logic [NUM_BRANCH*WIDTH-1:0]     branch_data,
    input  logic [NUM_BRANCH-1:0]           branch_valid,
    output logic                            branch_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [SEL_W(NUM_BRANCH)-1:0]    out_sel,
    output logic                            out_else,
    output logic                            err_multi
);

    localparam int c_SEL_W   = SEL_W(NUM_BRANCH);
    localparam int c_ENTRY_W = $bits(sel_entry_t);

    logic [c_MAX_BRANCH-2:0] w_cond_ext;
    sel_entry_t              w_enc;
    sel_entry_t              w_head;
    logic [c_ENTRY_W-1:0]    w_head_bits;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_fire;
    logic                    w_can_load;
    logic                    w_multi;
    logic                    w_unused;
    logic [WIDTH-1:0]        w_branch [NUM_BRANCH];

    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_out_data;
    logic [c_SEL_W-1:0]      r_out_sel;
    logic                    r_out_else;
    logic                    r_err_multi;

    generate
        for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_unpack
            assign w_branch[gi] = branch_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        w_cond_ext                 = '0;
        w_cond_ext[NUM_BRANCH-2:0] = cond_vec;
    end

    assign w_enc   = prio_encode(w_cond_ext, NUM_BRANCH);
    assign w_multi = |(cond_vec & (cond_vec - 1'b1));

    // Credit comes from the current count only; a same-cycle pop does not free a slot.
    assign in_ready     = ~w_full;
    assign w_push       = in_valid & in_ready;
    assign w_can_load   = ~r_out_valid | out_ready;
    assign w_fire       = ~reset & ~w_empty & (&branch_valid) & w_can_load;
    assign branch_ready = w_fire;

    sel_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_sel_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_enc),
        .i_pop   (w_fire),
        .o_rdata (w_head_bits),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head   = w_head_bits;
    assign w_unused = ^{w_count, w_head.sel[c_MAX_SEL_W-1:c_SEL_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_else  <= 1'b0;
            r_err_multi <= 1'b0;
        end else begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_branch[w_head.sel[c_SEL_W-1:0]];
                r_out_sel   <= w_head.sel[c_SEL_W-1:0];
                r_out_else  <= w_head.else_flag;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_push && (ONEHOT_CHK != 0) && w_multi) begin
                r_err_multi <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_else  = r_out_else;
    assign err_multi = r_err_multi;

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full));
    a_no_fire_empty: assert property (@(posedge clk) disable iff (reset)
        !(w_fire && w_empty));
    a_hold_data: assert property (@(posedge clk) disable iff (reset)
        (r_out_valid && !out_ready) |=> $stable(r_out_data));

endmodule
`default_nettype wire

// File: tb/tb_cond_branch_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_branch_merge
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_branch_merge;

    localparam int c_W  = 32;
    localparam int c_NB = 4;
    localparam int c_D  = 4;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [c_NB-2:0]       cond_vec;
    logic [c_NB*c_W-1:0]   branch_data;
    logic [c_NB-1:0]       branch_valid;
    logic                  branch_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [c_W-1:0]        out_data;
    logic [1:0]            out_sel;
    logic                  out_else;
    logic                  err_multi;

    cond_branch_merge #(
        .WIDTH      (c_W),
        .NUM_BRANCH (c_NB),
        .DEPTH      (c_D),
        .ONEHOT_CHK (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cond_vec     (cond_vec),
        .branch_data  (branch_data),
        .branch_valid (branch_valid),
        .branch_ready (branch_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .out_else     (out_else),
        .err_multi    (err_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_q[$];
    bit          m_valid;
    bit          m_else;
    bit          m_err;
    bit          m_fire;
    logic [31:0] m_data;
    int          m_sel;

    function automatic int ref_sel(input logic [c_NB-2:0] c);
        for (int i = 0; i < c_NB - 1; i++) begin
            if (c[i]) return i;
        end
        return c_NB - 1;
    endfunction

    function automatic int popc(input logic [c_NB-2:0] c);
        int n = 0;
        for (int i = 0; i < c_NB - 1; i++) n += int'(c[i]);
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: check handshake outputs before the edge, advance the model, check registers after.
    task automatic cycle();
        bit push;
        int s;
        #1;
        m_fire = !reset && (m_q.size() != 0) && (&branch_valid) && (!m_valid || out_ready);
        push   = in_valid && (m_q.size() < c_D);
        check_val("in_ready", in_ready, m_q.size() < c_D);
        check_val("branch_ready", branch_ready, m_fire);
        if (reset) begin
            m_q.delete();
            m_valid = 0;
            m_data  = '0;
            m_sel   = 0;
            m_else  = 0;
            m_err   = 0;
        end else begin
            if (m_fire) begin
                s       = m_q.pop_front();
                m_data  = branch_data[s*c_W +: c_W];
                m_sel   = s;
                m_else  = (s == c_NB - 1);
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (push) begin
                m_q.push_back(ref_sel(cond_vec));
                if (popc(cond_vec) > 1) m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        check_val("out_valid", out_valid, m_valid);
        check_val("out_data", out_data, m_data);
        check_val("out_sel", out_sel, m_sel);
        check_val("out_else", out_else, m_else);
        check_val("err_multi", err_multi, m_err);
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        cond_vec     = '0;
        branch_data  = '0;
        branch_valid = '0;
        out_ready    = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        repeat (5) cycle();

        // Priority and else selection with fixed branch results
        branch_data  = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
        branch_valid = '1;
        in_valid     = 1'b1;
        cond_vec = 3'b100; cycle();
        cond_vec = 3'b110; cycle();
        cond_vec = 3'b000; cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Fill with branches stalled, one refused push, then drain
        branch_valid = '0;
        in_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cond_vec = 3'(i);
            cycle();
        end
        in_valid     = 1'b0;
        branch_valid = '1;
        repeat (6) cycle();

        // Consumer backpressure
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cond_vec = 3'(1 << i);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) cycle();
        out_ready = 1'b1;
        repeat (5) cycle();

        // Sticky multi-true error
        reset = 1'b1; cycle(); reset = 1'b0;
        in_valid = 1'b1;
        cond_vec = 3'b011; cycle();
        cond_vec = 3'b001; cycle();
        cond_vec = 3'b100; cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Reset with queued entries and a held output
        out_ready    = 1'b0;
        branch_valid = '1;
        in_valid     = 1'b1;
        cond_vec     = 3'b001; cycle();
        cond_vec     = 3'b010; cycle();
        branch_valid = '0;
        cond_vec     = 3'b100; cycle();
        cond_vec     = 3'b000; cycle();
        in_valid     = 1'b0;
        reset        = 1'b1; cycle(); reset = 1'b0;
        out_ready    = 1'b1;
        branch_valid = '1;
        repeat (4) cycle();

        // Random traffic
        repeat (400) begin
            in_valid     = 1'($urandom_range(0, 1));
            cond_vec     = 3'($urandom());
            branch_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            branch_valid = ($urandom_range(0, 3) != 0) ? '1 : 4'($urandom());
            out_ready    = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_branch_merge.md
Name: cond_branch_merge

Overview:
Parametrised N-way successor to the generated two-way if/else combine blocks. It merges the results of NUM_BRANCH parallel branch datapaths into one output, selected by a priority-encoded condition vector. Branch datapaths have variable, unknown latency, so the block queues each selection decision and joins it later with the branch results. Valid/ready handshakes apply on all sides. It sits between the condition evaluators and the branch datapaths on one side and the downstream consumer on the other.

Parameters:
WIDTH, 32, data width of each branch result and of out_data
NUM_BRANCH, 4, branch count, minimum 2; index NUM_BRANCH-1 is the else branch
DEPTH, 4, selection queue depth, power of two, minimum 2
ONEHOT_CHK, 0, when 1, more than one true condition sets err_multi

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  a condition vector is presented
in_ready  out  1  selection queue can accept
cond_vec  in  NUM_BRANCH-1  per-branch conditions; bit i belongs to branch i; the else branch has no bit
branch_data  in  NUM_BRANCH*WIDTH  branch results; branch i occupies bits [i*WIDTH +: WIDTH]
branch_valid  in  NUM_BRANCH  per-branch result valid
branch_ready  out  1  common pop strobe to all branches; asserted only on a join fire
out_valid  out  1  output register holds data
out_ready  in  1  consumer accepts
out_data  out  WIDTH  selected result
out_sel  out  max(1,$clog2(NUM_BRANCH))  index of the selected branch
out_else  out  1  no condition was true, so the else branch was taken
err_multi  out  1  sticky: a multiple-true condition vector was accepted while ONEHOT_CHK=1

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, out_else=0, err_multi=0, queue empty (count=0, read/write pointers 0). branch_ready=0 because the queue is empty. in_ready=1 in the first cycle after reset.
- Reset asserted mid-operation discards all queued selections and the output register in the same edge. Branch data in flight is not popped.
- Selection encode (combinational, at input): sel = lowest i with cond_vec[i]=1, else sel=NUM_BRANCH-1 with else_flag=1.
- Queue push: push = in_valid & in_ready. Each entry stores {sel, else_flag}.
- in_ready = (count != DEPTH). It is decided from the current count only; a same-cycle pop grants no credit. A full queue therefore refuses input even while popping.
- Output register load condition: can_load = ~out_valid | out_ready.
- Join fire: fire = (count != 0) & (&branch_valid) & can_load.
  - branch_ready = fire.
  - On fire: out_data <= branch_data[head.sel]; out_sel <= head.sel; out_else <= head.else_flag; out_valid <= 1; pop the head.
- Pop without reload: if out_valid & out_ready & ~fire, then out_valid <= 0. out_data holds its last value.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Latency: in a drained pipe with all branch_valid high, a push at cycle t can fire at t+1 at the earliest, and out_valid rises at t+2. Full throughput is one result per cycle when out_ready=1.
- Ordering: results leave strictly in push order. Branch results are consumed in lock-step, one per branch per fire.
- err_multi: set on a push where ONEHOT_CHK=1 and popcount(cond_vec)>1. It stays set until reset. Selection still follows priority.
- Assertions for the verifier:
  - no push while count==DEPTH
  - no fire while count==0
  - out_data stable while out_valid & ~out_ready

Decomposition:
- Shared package:
  - SEL_W function (max(1,$clog2(n)))
  - sel_entry_t struct {sel, else_flag}
  - prio_encode function used by all generated merge blocks
- One sub-module, sel_fifo: a synchronous FIFO parametrised by entry width and DEPTH, exposing count, full and empty. It is reused by later generated branch blocks.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, branch_ready=0, err_multi=0 for 5 cycles.
- NUM_BRANCH=4, one result per branch (branch_data=[0xA0,0xB1,0xC2,0xD3], all branch_valid=1, out_ready=1), pushes issued in this order:
  - cond_vec=3'b100 -> out_data=0xC2, out_sel=2
  - cond_vec=3'b110 -> out_data=0xB1, out_sel=1 (priority)
  - cond_vec=3'b000 -> out_data=0xD3, out_sel=3, out_else=1
- Four pushes with branch_valid=0: in_ready drops after the 4th. A 5th push attempt is refused and count stays 4. Raising branch_valid drains 4 results in order on consecutive cycles.
- out_ready=0 for 3 cycles while out_valid=1: out_data is held constant and branch_ready=0. Then out_ready=1 resumes one result per cycle with no loss or duplication.
- ONEHOT_CHK=1, push cond_vec=3'b011: out_sel=0 and err_multi=1, which stays set after later legal pushes until reset.
- Reset asserted while the queue holds 3 entries and out_valid=1: on the next cycle out_valid=0, in_ready=1, and no stale entry ever emerges.
